// File: rtl/wb_init_pkg.sv
// -----------------------------------------------------------------------------
// wb_init_pkg
//
// Shared definitions for the Wishbone command initiator:
//   - state_t        : FSM state encoding (IDLE=0, BUS=1, RESP=2)
//   - DEF_ADDR_W     : default Wishbone address width
//   - DEF_DATA_W     : default Wishbone data width
//   - DEF_TIMEOUT    : default BUS-phase timeout in cycles
//   - tmo_cnt_w()    : width of the timeout counter for a given TIMEOUT
//
// The timeout logic is only built when WB_INIT_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
package wb_init_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 255;

   // Counter must be able to hold the value TIMEOUT itself.
   function automatic int tmo_cnt_w(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/wb_init_timer.sv
// -----------------------------------------------------------------------------
// wb_init_timer
//
// BUS-phase watchdog for wb_cmd_initiator. Only compiled when the macro
// WB_INIT_TIMEOUT_EN is defined; the initiator does not instantiate it
// otherwise.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   i_clear    in   hold the count at zero (asserted whenever not in BUS)
//   i_enable   in   count this cycle (BUS cycle without ack)
//   o_expired  out  the current BUS cycle is number TIMEOUT
//
// o_expired is asserted while the count equals TIMEOUT-1, i.e. during the
// TIMEOUT-th BUS cycle, so that the initiator aborts on the edge that ends
// that cycle and cyc is high for exactly TIMEOUT cycles.
// -----------------------------------------------------------------------------
`ifdef WB_INIT_TIMEOUT_EN
module wb_init_timer
   import wb_init_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = tmo_cnt_w(TIMEOUT)
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_expired = (r_count == LAST_CNT);

endmodule
`endif

// File: rtl/wb_cmd_initiator.sv
// -----------------------------------------------------------------------------
// wb_cmd_initiator
//
// Wishbone classic single-cycle master. Takes one command at a time on a
// valid/ready request port, runs a single Wishbone read or write, and
// returns the result on a valid/ready response port.
//
// Optional feature macro: WB_INIT_TIMEOUT_EN
//   defined   : BUS phase aborts after TIMEOUT cycles without ack and the
//               response carries rsp_err=1, rsp_rdata=0. Ack on the same
//               cycle as the timeout wins.
//   undefined : BUS waits forever for ack; rsp_err is always 0.
//
// Parameters:
//   ADDR_W   Wishbone address width
//   DATA_W   Wishbone data width (multiple of 8)
//   TIMEOUT  BUS-phase cycle limit, 1..65535 (used only with the macro)
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   cmd_valid/cmd_ready    request handshake
//   cmd_we/addr/wdata/sel  request payload
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     response payload (rdata is 0 for writes/errors)
//   wbm_*                  Wishbone master interface
//   busy                   high whenever a command is in flight
// -----------------------------------------------------------------------------
module wb_cmd_initiator
   import wb_init_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                clk,
   input  logic                reset,
   // command port
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_we,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_sel,
   // response port
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   // Wishbone master
   output logic                wbm_cyc_o,
   output logic                wbm_stb_o,
   output logic                wbm_we_o,
   output logic [DATA_W/8-1:0] wbm_sel_o,
   output logic [ADDR_W-1:0]   wbm_adr_o,
   output logic [DATA_W-1:0]   wbm_dat_o,
   input  logic [DATA_W-1:0]   wbm_dat_i,
   input  logic                wbm_ack_i,
   // status
   output logic                busy
);

   localparam int SEL_W = DATA_W / 8;

   // Elaboration-time parameter sanity checks.
   if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
      $error("wb_cmd_initiator: DATA_W must be a positive multiple of 8");
   end
   if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
      $error("wb_cmd_initiator: TIMEOUT must be in 1..65535");
   end

   state_t             r_state;
   logic               r_cyc;
   logic               r_we;
   logic [SEL_W-1:0]   r_sel;
   logic [ADDR_W-1:0]  r_adr;
   logic [DATA_W-1:0]  r_dat_o;
   logic [DATA_W-1:0]  r_rdata;
   logic               r_rsp_valid;
   logic               r_rsp_err;
   logic               r_cmd_ready;
   logic               r_busy;
   logic               w_timeout;

`ifdef WB_INIT_TIMEOUT_EN
   logic w_tmr_clear;
   logic w_tmr_enable;
   logic w_tmr_expired;

   // Count is held at zero outside BUS, so it starts from zero on entry.
   assign w_tmr_clear  = (r_state != BUS);
   assign w_tmr_enable = (r_state == BUS) && !wbm_ack_i;

   wb_init_timer #(
      .TIMEOUT   (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .i_clear   (w_tmr_clear),
      .i_enable  (w_tmr_enable),
      .o_expired (w_tmr_expired)
   );

   assign w_timeout = w_tmr_expired;
`else
   // No watchdog: BUS only leaves on ack, and rsp_err can never be set.
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cyc       <= 1'b0;
         r_we        <= 1'b0;
         r_sel       <= '0;
         r_adr       <= '0;
         r_dat_o     <= '0;
         r_rdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_we        <= cmd_we;
                  r_adr       <= cmd_addr;
                  r_dat_o     <= cmd_wdata;
                  r_sel       <= cmd_sel;
                  r_cyc       <= 1'b1;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= BUS;
               end
            end

            BUS: begin
               // Ack takes priority over a coincident timeout. cyc/stb drop
               // on this same edge so a registered-ack responder never sees
               // stb in the cycle after its ack.
               if (wbm_ack_i) begin
                  r_cyc       <= 1'b0;
                  r_rdata     <= r_we ? '0 : wbm_dat_i;
                  r_rsp_err   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else if (w_timeout) begin
                  r_cyc       <= 1'b0;
                  r_rdata     <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end
            end

            RESP: begin
               // cmd_ready rises only after the response handshake, so no
               // command is ever accepted on the handshake cycle itself.
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_state     <= IDLE;
               r_cyc       <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // cyc and stb share one register so they can never differ.
   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_cyc;
   assign wbm_we_o  = r_we;
   assign wbm_sel_o = r_sel;
   assign wbm_adr_o = r_adr;
   assign wbm_dat_o = r_dat_o;

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_rsp_err;
   assign busy      = r_busy;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_initiator
//
// Bench for wb_cmd_initiator with TIMEOUT=8. A memory-backed Wishbone
// responder with programmable registered-ack latency drives the bus side.
// A transaction-level model (command outstanding / response outstanding)
// predicts every DUT output and is compared on each falling edge. Directed
// scenarios add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_wb_cmd_initiator;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 8;
`ifdef WB_INIT_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_sel;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic [SW-1:0] wbm_sel_o;
   logic [AW-1:0] wbm_adr_o;
   logic [DW-1:0] wbm_dat_o, wbm_dat_i;
   logic          busy;

   always #5 clk = ~clk;

   wb_cmd_initiator #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .TIMEOUT   (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_sel   (cmd_sel),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .busy      (busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
   endtask

   // ---------------- responder (registered ack, latency rsp_lat) ----------
   int          rsp_lat   = 1;
   bit          silent    = 1'b0;
   bit          stray_req = 1'b0;
   int          r_cnt     = 0;
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : {a[15:0], 16'hC0DE};
   endfunction

   initial begin
      logic [31:0] w;
      wbm_ack_i = 1'b0;
      wbm_dat_i = '0;
      forever begin
         @(posedge clk);
         #2;
         if (stray_req) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = $urandom;
            stray_req = 1'b0;
            r_cnt     = 0;
         end else if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = $urandom;
            r_cnt     = 0;
         end else if (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1) begin
            wbm_dat_i = $urandom;
            if (!silent) begin
               r_cnt++;
               if (r_cnt > rsp_lat) begin
                  wbm_ack_i = 1'b1;
                  if (wbm_we_o) begin
                     w = rd_word(wbm_adr_o);
                     for (int b = 0; b < SW; b++)
                        if (wbm_sel_o[b]) w[8*b +: 8] = wbm_dat_o[8*b +: 8];
                     mem[wbm_adr_o] = w;
                  end else begin
                     wbm_dat_i = rd_word(wbm_adr_o);
                  end
               end
            end
         end else begin
            r_cnt     = 0;
            wbm_dat_i = $urandom;
         end
      end
   end

   // ---------------- rsp_ready driver: 0=low, 1=high, 2=random -----------
   int rdy_mode = 0;
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         rsp_ready = (rdy_mode == 2) ? 1'($urandom) : (rdy_mode == 1);
      end
   end

   // ---------------- transaction-level reference model --------------------
   // m_pend: a command has been accepted and its bus transfer is not done.
   // m_rsp : a result is waiting to be consumed.
   logic          m_pend, m_rsp, m_we, m_err;
   logic [SW-1:0] m_sel;
   logic [AW-1:0] m_adr;
   logic [DW-1:0] m_wd, m_rdata;
   int            m_k;

   always @(posedge clk) begin
      if (reset) begin
         m_pend <= 1'b0; m_rsp <= 1'b0; m_we <= 1'b0; m_err <= 1'b0;
         m_sel <= '0; m_adr <= '0; m_wd <= '0; m_rdata <= '0; m_k <= 0;
      end else if (m_pend) begin
         if (wbm_ack_i) begin
            m_pend <= 1'b0; m_rsp <= 1'b1; m_err <= 1'b0;
            m_rdata <= m_we ? '0 : wbm_dat_i;
         end else if (TMO_EN && (m_k + 1 == TMO)) begin
            m_pend <= 1'b0; m_rsp <= 1'b1; m_err <= 1'b1; m_rdata <= '0;
         end else begin
            m_k <= m_k + 1;
         end
      end else if (m_rsp) begin
         if (rsp_ready) m_rsp <= 1'b0;
      end else if (cmd_valid) begin
         m_pend <= 1'b1; m_k <= 0;
         m_we <= cmd_we; m_adr <= cmd_addr; m_wd <= cmd_wdata; m_sel <= cmd_sel;
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmd_ready", 64'(cmd_ready), 64'(!(m_pend || m_rsp)));
         chk("busy",      64'(busy),      64'(m_pend || m_rsp));
         chk("cyc",       64'(wbm_cyc_o), 64'(m_pend));
         chk("stb",       64'(wbm_stb_o), 64'(m_pend));
         chk("we",        64'(wbm_we_o),  64'(m_we));
         chk("sel",       64'(wbm_sel_o), 64'(m_sel));
         chk("adr",       64'(wbm_adr_o), 64'(m_adr));
         chk("dat_o",     64'(wbm_dat_o), 64'(m_wd));
         chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
         chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
         chk("rsp_err",   64'(rsp_err),   64'(m_err));
      end
   end

   // Length of the most recent contiguous cyc-high run.
   int cyc_run  = 0;
   int last_len = 0;
   always @(negedge clk) begin
      if (wbm_cyc_o === 1'b1) cyc_run++;
      else if (cyc_run > 0) begin
         last_len = cyc_run;
         cyc_run  = 0;
      end
   end

   // Hard stop in case something hangs outside a bounded wait.
   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus helpers ------------------------------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_sel = s;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("cmd_accept_wait", 64'(n < 200), 64'd1);
      tick();
      cmd_valid = 1'b0;
      cmd_we = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_sel = 4'($urandom);
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      chk("rsp_wait", 64'(rsp_valid), 64'd1);
   endtask

   task automatic finish_rsp();
      rdy_mode = 1;
      tick();
      rdy_mode = 0;
   endtask

   task automatic wait_cyc_low();
      int n = 0;
      while (wbm_cyc_o === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("cyc_low_wait", 64'(n < 100), 64'd1);
   endtask

   // ---------------- main sequence ---------------------------------------
   initial begin
      logic [31:0] hold;
      logic        rwe;
      logic [31:0] ra, rd;
      logic [3:0]  rs;
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_sel = '0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      tick(2);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_cyc",       64'(wbm_cyc_o), 64'd0);
      chk("rst_rdata",     64'(rsp_rdata), 64'd0);
      reset = 1'b0;
      tick();

      // Write then read back through a 1-cycle registered-ack responder.
      rsp_lat = 1;
      send_cmd(1'b1, 32'h3000_0000, 32'h0000_1234, 4'b0011);
      chk("wr_bus_we",  64'(wbm_we_o),  64'd1);
      chk("wr_bus_sel", 64'(wbm_sel_o), 64'h3);
      chk("wr_bus_adr", 64'(wbm_adr_o), 64'h3000_0000);
      wait_rsp();
      chk("wr_rdata", 64'(rsp_rdata), 64'd0);
      chk("wr_err",   64'(rsp_err),   64'd0);
      finish_rsp();
      chk("wr_cyc_len", 64'(last_len), 64'd2);

      send_cmd(1'b0, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF);
      wait_rsp();
      chk("rd_rdata", 64'(rsp_rdata), 64'h0000_1234);
      finish_rsp();
      chk("rd_cyc_len", 64'(last_len), 64'd2);

      // Response stall with a new command already waiting.
      send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
      wait_rsp();
      hold = rsp_rdata;
      cmd_we = 1'b1; cmd_addr = 32'h3000_0004; cmd_wdata = 32'hDEAD_BEEF; cmd_sel = 4'hF;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", 64'(rsp_valid), 64'd1);
         chk("stall_rdata", 64'(rsp_rdata), 64'(hold));
         chk("stall_ready", 64'(cmd_ready), 64'd0);
      end
      rdy_mode = 1;
      tick();
      chk("post_hs_ready", 64'(cmd_ready), 64'd1);
      chk("post_hs_cyc",   64'(wbm_cyc_o), 64'd0);
      rdy_mode = 0;
      tick();
      chk("accept_cyc", 64'(wbm_cyc_o), 64'd1);
      chk("accept_adr", 64'(wbm_adr_o), 64'h3000_0004);
      cmd_valid = 1'b0;
      wait_rsp();
      finish_rsp();

      // Stray ack while idle.
      tick(2);
      hold = rsp_rdata;
      stray_req = 1'b1;
      tick(3);
      chk("stray_idle_valid", 64'(rsp_valid), 64'd0);
      chk("stray_idle_busy",  64'(busy),      64'd0);
      chk("stray_idle_rdata", 64'(rsp_rdata), 64'(hold));

      // Stray ack while a response is waiting.
      send_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF);
      wait_rsp();
      chk("rd2_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
      tick();
      hold = rsp_rdata;
      stray_req = 1'b1;
      tick(3);
      chk("stray_resp_valid", 64'(rsp_valid), 64'd1);
      chk("stray_resp_rdata", 64'(rsp_rdata), 64'(hold));
      finish_rsp();
      chk("stray_resp_done", 64'(rsp_valid), 64'd0);

`ifdef WB_INIT_TIMEOUT_EN
      // Read to a responder that never acks.
      silent = 1'b1;
      send_cmd(1'b0, 32'h3000_0100, 32'h0, 4'hF);
      wait_rsp();
      chk("tmo_err",   64'(rsp_err),   64'd1);
      chk("tmo_rdata", 64'(rsp_rdata), 64'd0);
      finish_rsp();
      chk("tmo_cyc_len", 64'(last_len), 64'd8);
      silent = 1'b0;

      // Ack on the 8th BUS cycle beats the timeout.
      rsp_lat = 1;
      send_cmd(1'b1, 32'h3000_0200, 32'hA5A5_A5A5, 4'hF);
      wait_rsp();
      finish_rsp();
      rsp_lat = 7;
      send_cmd(1'b0, 32'h3000_0200, 32'h0, 4'hF);
      wait_rsp();
      chk("coin_err",   64'(rsp_err),   64'd0);
      chk("coin_rdata", 64'(rsp_rdata), 64'hA5A5_A5A5);
      finish_rsp();
      chk("coin_cyc_len", 64'(last_len), 64'd8);
      rsp_lat = 1;
`else
      // Without the watchdog a silent responder leaves the bus held.
      silent = 1'b1;
      send_cmd(1'b0, 32'h3000_0100, 32'h0, 4'hF);
      tick(1000);
      chk("hang_cyc",   64'(wbm_cyc_o), 64'd1);
      chk("hang_valid", 64'(rsp_valid), 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      silent = 1'b0;
      tick();
`endif

      // Reset two cycles into a read, then a late ack.
      silent = 1'b1;
      send_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_cyc",   64'(wbm_cyc_o), 64'd0);
      chk("mid_rst_stb",   64'(wbm_stb_o), 64'd0);
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_busy",  64'(busy),      64'd0);
      chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
      reset = 1'b0;
      silent = 1'b0;
      stray_req = 1'b1;
      tick(3);
      chk("late_ack_valid", 64'(rsp_valid), 64'd0);
      chk("late_ack_busy",  64'(busy),      64'd0);

      // Randomized traffic with random response back-pressure.
      rdy_mode = 2;
      for (int t = 0; t < 150; t++) begin
         rwe = 1'($urandom);
         ra  = 32'h3000_0000 + 32'(4 * $urandom_range(0, 7));
         rd  = $urandom;
         rs  = 4'($urandom);
         rsp_lat = TMO_EN ? $urandom_range(1, 9) : $urandom_range(1, 4);
         silent  = TMO_EN && ($urandom_range(0, 7) == 0);
         send_cmd(rwe, ra, rd, rs);
         wait_cyc_low();
      end
      rdy_mode = 1;
      tick(5);
      silent = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
- Wishbone classic single-cycle master: the initiator end of the bus our user-project responders (counter/keypad slaves) sit on.
- Accepts one command at a time on a valid/ready request port, runs one Wishbone read or write, and returns the result on a valid/ready response port.
- Used by the on-chip self-test and LA-driven sequencer to exercise slaves without the management SoC.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width; multiple of 8.
- TIMEOUT, 255, max cycles in BUS before abort (only with WB_INIT_TIMEOUT_EN); valid range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_sel  in  DATA_W/8  byte lanes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes/errors)
- rsp_err  out  1  transaction timed out
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  DATA_W/8  Wishbone byte select
- wbm_adr_o  out  ADDR_W  Wishbone address
- wbm_dat_o  out  DATA_W  Wishbone write data
- wbm_dat_i  in  DATA_W  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- busy  out  1  state != IDLE

Behaviour:
- Clock clk; reset is synchronous, active-high (reset reset).
- Reset: state=IDLE; cyc/stb/we=0; sel, adr, dat_o, rsp_rdata = 0; rsp_valid=0; rsp_err=0; busy=0.
- FSM states: IDLE, BUS, RESP.
  - IDLE: cmd_ready=1. On cmd_valid at edge N, latch we/addr/wdata/sel into the wbm_* registers, set cyc=stb=1, and go to BUS. Bus signals are visible from cycle N+1.
  - BUS: cmd_ready=0. All wbm_* outputs are held stable.
    - On the first edge with wbm_ack_i=1: cyc=stb=0.
    - Same edge: rsp_rdata = wbm_dat_i for reads, 0 for writes; rsp_err=0; rsp_valid=1; go to RESP.
  - RESP: rsp_valid stays high with rsp_rdata and rsp_err stable until rsp_ready. On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
- Throughput: no command is accepted in the same cycle as a response handshake. Back-to-back rate is one transaction per (ack latency + 2) cycles minimum.
- wbm_ack_i outside BUS is ignored; no state change.
- cyc and stb are always equal; stb never reasserts in the cycle after ack. This keeps responders that use registered ack and a "valid && !ready" guard from seeing a duplicate strobe.
- wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o keep their last values after cyc drops. Only cyc/stb qualify them.
- Reset mid-transaction returns to reset values on that edge:
  - cyc/stb drop.
  - Any pending response is discarded.
  - The in-flight command is not retried.
- cmd_* inputs are ignored when cmd_ready=0.

Optional Feature:
- Macro: WB_INIT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT with no ack: cyc=stb=0, rsp_err=1, rsp_rdata=0, rsp_valid=1, go to RESP.
  - If ack and timeout coincide, ack wins: rsp_err=0.
- Undefined: no counter; BUS waits forever for ack; rsp_err is tied 0.

Decomposition:
- Package wb_init_pkg holds:
  - FSM state encoding constants (IDLE=2'd0, BUS=2'd1, RESP=2'd2).
  - Default ADDR_W/DATA_W.
  - Timeout counter width, computed as clog2(TIMEOUT+1).
- One sub-module, wb_init_timer: clear/enable/expired counter. It is instantiated only under WB_INIT_TIMEOUT_EN.

Test Plan:
- Write then read: cmd write addr=0x3000_0000, wdata=0x0000_1234, sel=4'b0011 to a counter responder with 1-cycle registered ack.
  - Bus: cyc/stb high for exactly 2 cycles, we=1, sel=0011.
  - Response: rsp_valid with rdata=0, err=0.
  - Following read returns rdata=0x0000_1234 plus the elapsed count increments.
- Response stall: hold rsp_ready=0 for 5 cycles after the read ack.
  - rsp_valid/rsp_rdata stay stable.
  - cmd_ready stays 0.
  - A new cmd_valid is not accepted until the cycle after the rsp handshake.
- Stray ack: pulse wbm_ack_i while in IDLE and while in RESP.
  - No state change, no extra rsp_valid.
  - rsp_rdata is unchanged.
- Timeout (macro defined, TIMEOUT=8): read to a non-responding address.
  - cyc drops after exactly 8 BUS cycles.
  - Response: rsp_err=1, rdata=0.
  - Undefined-macro build: cyc is still high at cycle 1000.
- Coincident ack and timeout: ack arrives on the 8th BUS cycle with dat_i=0xA5A5_A5A5 → rsp_err=0, rdata=0xA5A5_A5A5.
- Reset mid-BUS: assert reset 2 cycles into a read.
  - Next edge: cyc/stb=0, rsp_valid=0, busy=0, cmd_ready=1.
  - A late ack is ignored.
